// File: rtl/pdm_pkg.sv
// pdm_pkg: shared constants and helpers for the PDM modulator.
// PDM_SECOND_ORDER_EN widens the per-channel state for the two-integrator loop.
package pdm_pkg;
  localparam int UNDERRUN_W = 16;
  function automatic int pdm_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction
  function automatic int pdm_min(input int width);
    return -(1 << (width - 1));
  endfunction
  function automatic int acc_width(input int width);
`ifdef PDM_SECOND_ORDER_EN
    return width + 4;
`else
    return width + 2;
`endif
  endfunction
endpackage

// File: rtl/pdm_channel.sv
// pdm_channel: one sigma-delta lane, first order by default.
// PDM_SECOND_ORDER_EN selects a saturating two-integrator cascade.
module pdm_channel import pdm_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clear_in,
  input  logic             tick_in,
  input  logic [WIDTH-1:0] level_in,
  output logic             pdm_out
);
  localparam int AW = acc_width(WIDTH);
  logic signed [AW-1:0] x, mx, mn;
  assign x  = {{(AW-WIDTH){level_in[WIDTH-1]}}, level_in};
  assign mx = AW'(pdm_max(WIDTH));
  assign mn = AW'(pdm_min(WIDTH));
`ifdef PDM_SECOND_ORDER_EN
  localparam int BW = AW + 2;
  localparam logic signed [BW-1:0] HI = BW'(pdm_max(AW));
  localparam logic signed [BW-1:0] LO = BW'(pdm_min(AW));
  logic signed [AW-1:0] i1, i2, fb, i1_next, i2_next;
  logic signed [BW-1:0] s1, s2;
  // sums are formed two bits wider, then clamped to the integrator range
  always_comb begin
    fb = i2 > 0 ? mx : mn;
    s1 = BW'(i1) + BW'(x) - BW'(fb);
    i1_next = s1 > HI ? AW'(HI) : s1 < LO ? AW'(LO) : AW'(s1);
    s2 = BW'(i2) + BW'(i1_next) - BW'(fb);
    i2_next = s2 > HI ? AW'(HI) : s2 < LO ? AW'(LO) : AW'(s2);
  end
  always_ff @(posedge clk_in)
    if (rst_in || clear_in) begin
      i1 <= '0;
      i2 <= '0;
      pdm_out <= 1'b0;
    end else if (tick_in) begin
      i1 <= i1_next;
      i2 <= i2_next;
      pdm_out <= i2_next > 0;
    end
`else
  logic signed [AW-1:0] e, e_next;
  assign e_next = e + x - (e > 0 ? mx : mn);
  always_ff @(posedge clk_in)
    if (rst_in || clear_in) begin
      e <= '0;
      pdm_out <= 1'b0;
    end else if (tick_in) begin
      e <= e_next;
      pdm_out <= e_next > 0;
    end
`endif
endmodule

// File: rtl/pdm_modulator_multi.sv
// pdm_modulator_multi: multi-channel PDM modulator with shared tick, one-deep frame buffer
// and underrun counter. PDM_SECOND_ORDER_EN selects second-order channels.
module pdm_modulator_multi import pdm_pkg::*; #(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 8,
  parameter int TICK_PERIOD = 32
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      enable_in,
  input  logic [CHANNELS*WIDTH-1:0] level_in,
  input  logic                      level_valid_in,
  output logic                      level_ready_out,
  output logic [CHANNELS-1:0]       pdm_out,
  output logic                      pdm_clk_out,
  output logic                      tick_out,
  output logic [UNDERRUN_W-1:0]     underrun_count_out
);
  localparam int CW = $clog2(TICK_PERIOD);
  logic [CW-1:0] cnt, cnt_next;
  logic [CHANNELS*WIDTH-1:0] pending, active, sample;
  logic pending_valid, accept;
  assign tick_out        = enable_in && !rst_in && cnt == CW'(TICK_PERIOD - 1);
  assign cnt_next        = !enable_in || tick_out ? '0 : cnt + 1'b1;
  assign level_ready_out = !pending_valid && !rst_in;
  assign accept          = level_valid_in && level_ready_out;
  // a tick with a full buffer consumes the fresh frame immediately
  assign sample          = pending_valid ? pending : active;
  always_ff @(posedge clk_in)
    if (rst_in) begin
      cnt <= '0;
      pdm_clk_out <= 1'b0;
      pending <= '0;
      active <= '0;
      pending_valid <= 1'b0;
      underrun_count_out <= '0;
    end else begin
      cnt <= cnt_next;
      pdm_clk_out <= enable_in && cnt_next < CW'(TICK_PERIOD / 2);
      active <= tick_out ? sample : active;
      pending <= accept ? level_in : pending;
      pending_valid <= accept || (pending_valid && !tick_out);
      if (tick_out && !pending_valid && underrun_count_out != '1)
        underrun_count_out <= underrun_count_out + 1'b1;
    end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    pdm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .clear_in(!enable_in),
      .tick_in (tick_out),
      .level_in(sample[c*WIDTH +: WIDTH]),
      .pdm_out (pdm_out[c])
    );
  end
endmodule

// File: tb/tb_pdm_modulator_multi.sv
// tb_pdm_modulator_multi: directed and randomized checks against a behavioural model.
module tb_pdm_modulator_multi;
  localparam int CH = 2, W = 8, P = 4, MAXV = 127, MINV = -128, ILIM = 2048;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, valid = 1'b0;
  logic [CH*W-1:0] level = '0;
  logic ready, pclk, tick;
  logic [CH-1:0] pdm;
  logic [15:0] und;
  int tests = 0, fails = 0;
  int m_cnt, m_und, m_pend[CH], m_act[CH], m_e1[CH], m_e2[CH], ones[CH];
  bit m_pclk, m_pv, m_pdm[CH], last_tick;

  always #5 clk = ~clk;

  pdm_modulator_multi #(.CHANNELS(CH), .WIDTH(W), .TICK_PERIOD(P)) dut (
    .clk_in(clk), .rst_in(rst), .enable_in(en), .level_in(level),
    .level_valid_in(valid), .level_ready_out(ready), .pdm_out(pdm),
    .pdm_clk_out(pclk), .tick_out(tick), .underrun_count_out(und)
  );

  function automatic int lane(logic [CH*W-1:0] v, int c);
    return int'($signed(v[c*W +: W]));
  endfunction

  function automatic int sat(int v);
    return v > ILIM - 1 ? ILIM - 1 : v < -ILIM ? -ILIM : v;
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(string name, int act, int lo, int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // One clock: advance the model from the inputs seen at this edge, then compare at negedge.
  task automatic step();
    bit t, acc;
    int x, fb, mp;
    t = en && !rst && m_cnt == P - 1;
    acc = valid && !m_pv && !rst;
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_und = 0; m_pclk = 0; m_pv = 0;
      for (int c = 0; c < CH; c++) begin
        m_pend[c] = 0; m_act[c] = 0; m_e1[c] = 0; m_e2[c] = 0; m_pdm[c] = 0;
      end
    end else begin
      if (t) begin
        for (int c = 0; c < CH; c++) begin
          x = m_pv ? m_pend[c] : m_act[c];
          m_act[c] = x;
`ifdef PDM_SECOND_ORDER_EN
          fb = m_e2[c] > 0 ? MAXV : MINV;
          m_e1[c] = sat(m_e1[c] + x - fb);
          m_e2[c] = sat(m_e2[c] + m_e1[c] - fb);
          m_pdm[c] = m_e2[c] > 0;
`else
          fb = m_e1[c] > 0 ? MAXV : MINV;
          m_e1[c] = m_e1[c] + x - fb;
          m_pdm[c] = m_e1[c] > 0;
`endif
        end
        if (!m_pv) m_und = m_und == 65535 ? 65535 : m_und + 1;
      end
      if (acc)
        for (int c = 0; c < CH; c++) m_pend[c] = lane(level, c);
      m_pv = acc || (m_pv && !t);
      if (!en)
        for (int c = 0; c < CH; c++) begin
          m_e1[c] = 0; m_e2[c] = 0; m_pdm[c] = 0;
        end
      m_cnt = en ? (m_cnt + 1) % P : 0;
      m_pclk = en && m_cnt < P / 2;
    end
    @(negedge clk);
    mp = 0;
    for (int c = 0; c < CH; c++) mp += int'(m_pdm[c]) << c;
    check("tick", int'(tick), int'(en && !rst && m_cnt == P - 1));
    check("ready", int'(ready), int'(!m_pv && !rst));
    check("pdm_clk", int'(pclk), int'(m_pclk));
    check("pdm", int'(pdm), mp);
    check("underrun", int'(und), m_und);
    if (last_tick)
      for (int c = 0; c < CH; c++) ones[c] += int'(pdm[c]);
    last_tick = tick;
  endtask

  task automatic clear_ones();
    for (int c = 0; c < CH; c++) ones[c] = 0;
  endtask

  // Steps until n ticks are seen, plus the cycle in which their bits appear.
  task automatic run_ticks(int n);
    int k = 0;
    for (int g = 0; g < n * P * 4 + 8 && k < n; g++) begin
      step();
      if (tick) k++;
    end
    check("tick_budget", k, n);
    step();
  endtask

  task automatic do_reset();
    rst = 1; en = 0; valid = 0; level = '0;
    repeat (3) step();
    check("rst_pdm", int'(pdm), 0);
    check("rst_und", int'(und), 0);
    check("rst_pclk", int'(pclk), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_ready", int'(ready), 0);
    rst = 0;
    #1;
    check("ready_after_rst", int'(ready), 1);
    last_tick = 0;
    clear_ones();
  endtask

  initial begin
    int exp_tk[8] = '{0, 0, 1, 0, 0, 0, 1, 0};
    int exp_pc[8] = '{1, 0, 0, 1, 1, 0, 0, 1};
    int und0;
    bit bp_p8, ov_p8;
`ifdef PDM_SECOND_ORDER_EN
    bp_p8 = 1; ov_p8 = 1;
`else
    bp_p8 = 0; ov_p8 = 0;
`endif
    do_reset();
    // tick and bit-clock cadence
    en = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("tick_pattern", int'(tick), exp_tk[i]);
      check("pclk_pattern", int'(pclk), exp_pc[i]);
    end
    // full scale both polarities
    do_reset();
    en = 1; valid = 1; level = {8'h80, 8'h7F};
    run_ticks(32);
    check("full_pos_ones", ones[0], 32);
    check("full_neg_ones", ones[1], 0);
    // midscale density, then underrun with sample reuse
    do_reset();
    en = 1; valid = 1; level = '0;
    run_ticks(256);
    check_range("mid_ones", ones[0], 127, 129);
    check("mid_no_underrun", int'(und), 0);
    valid = 0; clear_ones();
    run_ticks(10);
    check("underrun_10", int'(und), 10);
    check_range("reuse_ones", ones[0], 4, 6);
    // density at level 64
    do_reset();
    en = 1; valid = 1; level = {8'd64, 8'd64};
    run_ticks(256);
    check_range("l64_ones", ones[0], 190, 194);
    // backpressure: A accepted, B held until after the tick
    do_reset();
    en = 1; valid = 1; level = {8'h00, 8'h7F};
    step();
    check("bp_ready_drop", int'(ready), 0);
    level = {8'h00, 8'h80};
    step(); step(); step();
    check("bp_pdm_a", int'(pdm[0]), 1);
    check("bp_ready_free", int'(ready), 1);
    step();
    check("bp_b_accept", int'(ready), 0);
    step(); step(); step();
    check("bp_pdm_b", int'(pdm[0]), int'(bp_p8));
    check("bp_und", int'(und), 0);
    // accept on the tick cycle
    do_reset();
    en = 1;
    step(); step(); step();
    check("ov_tick", int'(tick), 1);
    valid = 1; level = {8'h00, 8'h80};
    step();
    valid = 0;
    check("ov_und", int'(und), 1);
    check("ov_pdm_old", int'(pdm[0]), 1);
    check("ov_pending", int'(ready), 0);
    repeat (4) step();
    check("ov_pdm_new", int'(pdm[0]), int'(ov_p8));
    check("ov_und_after", int'(und), 1);
    // mid-stream reset drops the pending frame
    do_reset();
    en = 1; valid = 1; level = {8'h40, 8'hC0};
    run_ticks(3);
    step();
    check("mr_pending", int'(ready), 0);
    rst = 1;
    step();
    check("mr_pdm", int'(pdm), 0);
    check("mr_pclk", int'(pclk), 0);
    rst = 0; valid = 0;
    #1;
    check("mr_ready", int'(ready), 1);
    run_ticks(1);
    check("mr_und", int'(und), 1);
    check("mr_pdm_zero_in", int'(pdm), 3);
    // randomized traffic against the model
    und0 = 0;
    for (int i = 0; i < 4000; i++) begin
      rst = $urandom_range(0, 299) == 0;
      en = $urandom_range(0, 15) != 0;
      valid = $urandom_range(0, 2) != 0;
      level = $urandom_range(0, 3) == 0 ? {8'h7F, 8'h80} : CH*W'($urandom);
      step();
      if (tick) und0++;
    end
    check_range("rand_ticks_seen", und0, 100, 1200);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
